// File: rtl/sram_arb_pkg.sv
// Shared widths, requester ids and the port-0 request word for the SRAM front end.
package sram_arb_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 9;
  localparam int NUM_WMASKS   = DATA_WIDTH / 8;
  localparam int READ_LATENCY = 3;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    req_id_t               id;
  } port0_req_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way grant for macro port 0; round-robin under SRAM_ARB_ROUND_ROBIN_EN, else fixed A-over-B.
// Grant is combinational from valid (and pointer); the pointer moves only on a granted request.
module sram_rr_arbiter
  import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Holds the requester that wins the next tie.
  req_id_t prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_A;
    end else if (a_grant) begin
      prio <= REQ_B;
    end else if (b_grant) begin
      prio <= REQ_A;
    end
  end

  always_comb begin
    a_grant = a_valid & (~b_valid | (prio == REQ_A));
    b_grant = b_valid & (~a_valid | (prio == REQ_B));
  end
`else
  assign a_grant = a_valid;
  assign b_grant = b_valid & ~a_valid;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Front end for the 32x512 1RW/1R macro: A/B share port 0, C reads port 1; fixed 3-cycle read latency.
// Tie-break set by SRAM_ARB_ROUND_ROBIN_EN; C stalls only on a same-cycle port-0 write to its address.
module sram_port_arbiter
  import sram_arb_pkg::*;
(
  input  logic                  clk0,
  input  logic                  rst0,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,

  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,

  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  logic       a_grant;
  logic       b_grant;
  logic       accept0;
  port0_req_t sel_req;
  port0_req_t issue;
  logic       issue_v;
  logic       rd_pend;
  req_id_t    rd_id;

  logic                  c_accept;
  logic                  c_issue_v;
  logic [ADDR_WIDTH-1:0] c_issue_addr;
  logic                  c_pend;

  sram_rr_arbiter u_arb (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .clk     (clk0),
    .rst     (rst0),
`endif
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_grant (a_grant),
    .b_grant (b_grant)
  );

  assign a_ready = a_grant;
  assign b_ready = b_grant;
  assign accept0 = a_grant | b_grant;

  always_comb begin
    sel_req = '0;
    if (b_grant) begin
      sel_req.we    = b_we;
      sel_req.wmask = b_wmask;
      sel_req.addr  = b_addr;
      sel_req.wdata = b_wdata;
      sel_req.id    = REQ_B;
    end else begin
      sel_req.we    = a_we;
      sel_req.wmask = a_wmask;
      sel_req.addr  = a_addr;
      sel_req.wdata = a_wdata;
      sel_req.id    = REQ_A;
    end
  end

  // A port-1 read sampled in the same macro cycle as a port-0 write to that word is undefined.
  assign c_ready  = ~(accept0 & sel_req.we & (sel_req.addr == c_addr));
  assign c_accept = c_valid & c_ready;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      issue_v <= 1'b0;
      issue   <= '0;
    end else begin
      issue_v <= accept0;
      if (accept0) begin
        issue <= sel_req;
      end
    end
  end

  // Gate web0 with issue_v so an idle port never looks like a pending write.
  assign sram_csb0   = ~issue_v;
  assign sram_web0   = ~(issue_v & issue.we);
  assign sram_wmask0 = issue.wmask;
  assign sram_addr0  = issue.addr;
  assign sram_din0   = issue.wdata;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_pend  <= 1'b0;
      rd_id    <= REQ_A;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      rd_pend  <= issue_v & ~issue.we;
      rd_id    <= issue.id;
      a_rvalid <= rd_pend & (rd_id == REQ_A);
      b_rvalid <= rd_pend & (rd_id == REQ_B);
      if (rd_pend && (rd_id == REQ_A)) begin
        a_rdata <= sram_dout0;
      end
      if (rd_pend && (rd_id == REQ_B)) begin
        b_rdata <= sram_dout0;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      c_issue_v    <= 1'b0;
      c_issue_addr <= '0;
      c_pend       <= 1'b0;
      c_rvalid     <= 1'b0;
      c_rdata      <= '0;
    end else begin
      c_issue_v <= c_accept;
      if (c_accept) begin
        c_issue_addr <= c_addr;
      end
      c_pend   <= c_issue_v;
      c_rvalid <= c_pend;
      if (c_pend) begin
        c_rdata <= sram_dout1;
      end
    end
  end

  assign sram_csb1  = ~c_issue_v;
  assign sram_addr1 = c_issue_addr;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with a behavioural 1RW/1R macro; tie expectations follow SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_port_arbiter;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        a_valid, a_ready, a_we, a_rvalid;
  logic [3:0]  a_wmask;
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_we, b_rvalid;
  logic [3:0]  b_wmask;
  logic [8:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        c_valid, c_ready, c_rvalid;
  logic [8:0]  c_addr;
  logic [31:0] c_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  always #5 clk0 = ~clk0;

  sram_port_arbiter dut (
    .clk0(clk0), .rst0(rst0),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Macro model: controls latched at posedge, array access and dout update at the following negedge.
  logic [31:0] mem [512];
  logic        p0_csb = 1'b1, p0_web = 1'b1, p1_csb = 1'b1;
  logic [3:0]  p0_mask;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_din;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  end

  always @(posedge clk0) begin
    p0_csb  <= sram_csb0;
    p0_web  <= sram_web0;
    p0_mask <= sram_wmask0;
    p0_addr <= sram_addr0;
    p0_din  <= sram_din0;
    p1_csb  <= sram_csb1;
    p1_addr <= sram_addr1;
  end

  always @(negedge clk0) begin
    if (!p0_csb) begin
      if (!p0_web) begin
        for (int i = 0; i < 4; i++)
          if (p0_mask[i]) mem[p0_addr][8*i +: 8] = p0_din[8*i +: 8];
      end else begin
        sram_dout0 <= mem[p0_addr];
      end
    end
    if (!p1_csb) sram_dout1 <= mem[p1_addr];
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        qa[$], qb[$], qc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] a_exp, b_exp, c_exp;
  logic        drop_resp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk0) cyc <= cyc + 1;

  // Scoreboard: pop on each strobe, push on each accepted read handshake.
  always @(negedge clk0) begin
    exp_t e;
    if (a_rvalid === 1'b1) begin
      if (qa.size() == 0) check("a_rvalid_unexpected", {31'b0, a_rvalid}, 32'd0);
      else begin
        e = qa.pop_front();
        check("a_rdata", a_rdata, e.data);
        check("a_latency", cyc, e.cyc);
      end
    end
    if (b_rvalid === 1'b1) begin
      if (qb.size() == 0) check("b_rvalid_unexpected", {31'b0, b_rvalid}, 32'd0);
      else begin
        e = qb.pop_front();
        check("b_rdata", b_rdata, e.data);
        check("b_latency", cyc, e.cyc);
      end
    end
    if (c_rvalid === 1'b1) begin
      if (qc.size() == 0) check("c_rvalid_unexpected", {31'b0, c_rvalid}, 32'd0);
      else begin
        e = qc.pop_front();
        check("c_rdata", c_rdata, e.data);
        check("c_latency", cyc, e.cyc);
      end
    end
    if (!drop_resp && !rst0) begin
      if (a_valid && a_ready && !a_we) qa.push_back('{a_exp, cyc + 3});
      if (b_valid && b_ready && !b_we) qb.push_back('{b_exp, cyc + 3});
      if (c_valid && c_ready) qc.push_back('{c_exp, cyc + 3});
    end
  end

  task automatic clr();
    a_valid = 0; a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0; a_exp = 0;
    b_valid = 0; b_we = 0; b_wmask = 0; b_addr = 0; b_wdata = 0; b_exp = 0;
    c_valid = 0; c_addr = 0; c_exp = 0;
  endtask

  task automatic set_a(input logic we, input logic [3:0] m, input logic [8:0] ad,
                       input logic [31:0] wd, input logic [31:0] ex);
    a_valid = 1; a_we = we; a_wmask = m; a_addr = ad; a_wdata = wd; a_exp = ex;
  endtask

  task automatic set_b(input logic we, input logic [3:0] m, input logic [8:0] ad,
                       input logic [31:0] wd, input logic [31:0] ex);
    b_valid = 1; b_we = we; b_wmask = m; b_addr = ad; b_wdata = wd; b_exp = ex;
  endtask

  task automatic set_c(input logic [8:0] ad, input logic [31:0] ex);
    c_valid = 1; c_addr = ad; c_exp = ex;
  endtask

  // Checks the three readies mid-cycle, then advances past the next posedge.
  task automatic cycle(input string tag, input logic ea, input logic eb, input logic ec);
    @(negedge clk0);
    check({tag, "_a_ready"}, {31'b0, a_ready}, {31'b0, ea});
    check({tag, "_b_ready"}, {31'b0, b_ready}, {31'b0, eb});
    check({tag, "_c_ready"}, {31'b0, c_ready}, {31'b0, ec});
    @(posedge clk0); #1;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) cycle("idle", 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clr();
    rst0 = 1;
    repeat (3) @(posedge clk0);
    #1;
    @(negedge clk0);
    check("rst_csb0", {31'b0, sram_csb0}, 32'd1);
    check("rst_csb1", {31'b0, sram_csb1}, 32'd1);
    check("rst_web0", {31'b0, sram_web0}, 32'd1);
    check("rst_addr0", {23'b0, sram_addr0}, 32'd0);
    check("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_c_rdata", c_rdata, 32'd0);
    @(posedge clk0); #1;
    rst0 = 0;

    // Basic write then read on A.
    clr(); set_a(1, 4'hF, 9'h005, 32'hDEADBEEF, 0);          cycle("wr5", 1, 0, 1);
    clr(); set_a(0, 4'h0, 9'h005, 0, 32'hDEADBEEF);          cycle("rd5", 1, 0, 1);
    idle(4);

    // Seed words for the tie test; B alone is granted too.
    clr(); set_a(1, 4'hF, 9'h010, 32'h10101010, 0);          cycle("wr10", 1, 0, 1);
    clr(); set_b(1, 4'hF, 9'h011, 32'h22221111, 0);          cycle("wr11", 0, 1, 1);

    for (int i = 0; i < 4; i++) begin
      clr();
      set_a(0, 4'h0, 9'h010, 0, 32'h10101010);
      set_b(0, 4'h0, 9'h011, 0, 32'h22221111);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      cycle("tie", ~i[0], i[0], 1);
`else
      cycle("tie", 1, 0, 1);
`endif
    end
    idle(4);

    // Partial write merges byte lanes 0 and 2.
    clr(); set_a(1, 4'hF, 9'h020, 32'h11223344, 0);          cycle("pw_full", 1, 0, 1);
    clr(); set_a(1, 4'b0101, 9'h020, 32'hAABBCCDD, 0);       cycle("pw_part", 1, 0, 1);
    clr(); set_a(0, 4'h0, 9'h020, 0, 32'h11BB33DD);          cycle("pw_rd", 1, 0, 1);
    idle(4);

    // Collision stall, then retry reads the new data.
    clr(); set_b(1, 4'hF, 9'h030, 32'hCAFEF00D, 0); set_c(9'h030, 32'hCAFEF00D);
    cycle("coll", 0, 1, 0);
    clr(); set_c(9'h030, 32'hCAFEF00D);                      cycle("coll_retry", 0, 0, 1);
    // A write to a different word and a read to the same word do not stall C.
    clr(); set_a(1, 4'hF, 9'h006, 32'h66666666, 0); set_c(9'h005, 32'hDEADBEEF);
    cycle("nocoll_wr", 1, 0, 1);
    clr(); set_a(0, 4'h0, 9'h020, 0, 32'h11BB33DD); set_c(9'h020, 32'h11BB33DD);
    cycle("nocoll_rd", 1, 0, 1);
    idle(4);

    // Back-to-back mixed-requester reads.
    clr(); set_a(1, 4'hF, 9'h001, 32'h00000111, 0);          cycle("wr1", 1, 0, 1);
    clr(); set_a(1, 4'hF, 9'h002, 32'h00000222, 0);          cycle("wr2", 1, 0, 1);
    clr(); set_a(1, 4'hF, 9'h003, 32'h00000333, 0);          cycle("wr3", 1, 0, 1);
    clr(); set_a(0, 4'h0, 9'h001, 0, 32'h00000111);          cycle("b2b_a1", 1, 0, 1);
    clr(); set_b(0, 4'h0, 9'h002, 0, 32'h00000222);          cycle("b2b_b2", 0, 1, 1);
    clr(); set_a(0, 4'h0, 9'h003, 0, 32'h00000333);          cycle("b2b_a3", 1, 0, 1);
    idle(5);

    // Reset right after a read handshake drops the response.
    drop_resp = 1;
    clr(); set_a(0, 4'h0, 9'h005, 0, 32'hDEADBEEF);          cycle("drop_hs", 1, 0, 1);
    clr(); rst0 = 1;
    @(posedge clk0); #1;
    @(negedge clk0);
    check("midrst_csb0", {31'b0, sram_csb0}, 32'd1);
    check("midrst_csb1", {31'b0, sram_csb1}, 32'd1);
    check("midrst_a_rdata", a_rdata, 32'd0);
    @(posedge clk0); #1;
    rst0 = 0;
    drop_resp = 0;
    idle(4);

    // Pointer is back on A after reset.
    clr(); set_a(0, 4'h0, 9'h005, 0, 32'hDEADBEEF); set_b(0, 4'h0, 9'h020, 0, 32'h11BB33DD);
    cycle("post_rst_tie", 1, 0, 1);
    clr(); set_b(0, 4'h0, 9'h020, 0, 32'h11BB33DD);          cycle("post_rst_b", 0, 1, 1);
    idle(6);

    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);
    check("qc_drained", qc.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
